// File: rtl/rr_arb_mux.sv
// N-to-1 round-robin arbitrated mux with valid/ready on every input and one
// registered output stage; out_* are pure register outputs.
module rr_arb_mux #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 8,
  localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_next;
  logic [SEL_W-1:0] win;
  logic             grant_any;
  logic             load_en;
  logic             transfer;
  logic [WIDTH-1:0] sel_data;

  assign out_valid = (state_reg == FULL);
  assign load_en   = (!out_valid || out_ready) && !flush;
  assign transfer  = rst_n && load_en && grant_any;

  // Search ptr, ptr+1, ... wrapping at NUM_IN so non-power-of-2 counts work.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    win       = '0;
    idx       = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!grant_any && in_valid[idx]) begin
        grant_any = 1'b1;
        win       = SEL_W'(idx);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ready
      assign in_ready[gi] = transfer && (win == SEL_W'(gi));
    end
  endgenerate

  // Only the winning lane is sliced, so X on other lanes never reaches out_data.
  assign sel_data = in_data[int'(win)*WIDTH +: WIDTH];
  assign ptr_next = (int'(win) == NUM_IN - 1) ? '0 : win + 1'b1;

  always_comb begin
    state_next = state_reg;
    if (flush)
      state_next = EMPTY;
    else if (transfer)
      state_next = FULL;
    else if (state_reg == FULL && out_ready)
      state_next = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else begin
      state_reg <= state_next;
      if (transfer) begin
        out_data <= sel_data;
        out_sel  <= win;
        ptr      <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: stimulus pushes expected words, per-DUT
// monitors pop and compare whenever a word is handed to the consumer.
module tb_rr_arb_mux;
  localparam int W  = 16;
  localparam int N  = 8;
  localparam int N5 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, flush, out_ready, out_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;

  logic            flush5, out_ready5, out_valid5;
  logic [N5*W-1:0] in_data5;
  logic [N5-1:0]   in_valid5, in_ready5;
  logic [W-1:0]    out_data5;
  logic [2:0]      out_sel5;

  rr_arb_mux #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  rr_arb_mux #(.WIDTH(W), .NUM_IN(N5)) dut5 (
    .clk(clk), .rst_n(rst_n), .flush(flush5), .in_data(in_data5),
    .in_valid(in_valid5), .in_ready(in_ready5), .out_data(out_data5),
    .out_sel(out_sel5), .out_valid(out_valid5), .out_ready(out_ready5)
  );

  typedef struct {
    logic [15:0] d;
    logic [2:0]  s;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp5_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Words consumed (valid & ready) are compared; a flushed word is discarded.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL out_word: got unexpected sel=%0d data=0x%0h, required none", out_sel, out_data);
      end else begin
        e = exp_q.pop_front();
        $display("xfer8 sel=%0d data=0x%0h (exp sel=%0d data=0x%0h)", out_sel, out_data, e.s, e.d);
        check("out_data", {16'h0, out_data}, {16'h0, e.d});
        check("out_sel", {29'h0, out_sel}, {29'h0, e.s});
      end
    end else if (rst_n && out_valid && flush) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      $display("flush8 discarded sel=%0d data=0x%0h", out_sel, out_data);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid5 && out_ready5) begin
      if (exp5_q.size() == 0) begin
        total_cnt++;
        $display("FAIL out5_word: got unexpected sel=%0d data=0x%0h, required none", out_sel5, out_data5);
      end else begin
        e = exp5_q.pop_front();
        $display("xfer5 sel=%0d data=0x%0h (exp sel=%0d data=0x%0h)", out_sel5, out_data5, e.s, e.d);
        check("out5_data", {16'h0, out_data5}, {16'h0, e.d});
        check("out5_sel", {29'h0, out_sel5}, {29'h0, e.s});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = '1; in_data = '0;
    flush5 = 1'b0; out_ready5 = 1'b0; in_valid5 = '0; in_data5 = '0;
    #12;
    check("rst_in_ready", {24'h0, in_ready}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", {16'h0, out_data}, 32'h0);
    check("rst_out_sel", {29'h0, out_sel}, 32'h0);
    in_valid = '0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Single request on ch3; other lanes carry X
    in_data = 'x;
    in_data[3*W +: W] = 16'h1234;
    in_valid = 8'b0000_1000;
    out_ready = 1'b1;
    #1 check("single_in_ready", {24'h0, in_ready}, 32'h08);
    exp_q.push_back('{16'h1234, 3'd3});
    step();
    in_valid = '0; in_data = '0;
    step();
    check("single_drained", {31'h0, out_valid}, 32'h0);

    // ptr is now 4: load 0xBEEF from ch4 and hold it, then reset mid-stream
    out_ready = 1'b0;
    in_data[4*W +: W] = 16'hBEEF;
    in_valid = 8'b0001_0000;
    #1 check("ptr4_in_ready", {24'h0, in_ready}, 32'h10);
    step();
    in_valid = '0;
    check("full_data", {16'h0, out_data}, 32'hBEEF);
    check("full_sel", {29'h0, out_sel}, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_data", {16'h0, out_data}, 32'h0);
    check("midrst_sel", {29'h0, out_sel}, 32'h0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;

    // Round robin from ch0 at full throughput: sel 0..7,0,1,2
    for (int k = 0; k < N; k++) in_data[k*W +: W] = 16'(16'h0100 + k);
    in_valid = '1;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      #1;
      check("rr_in_ready", {24'h0, in_ready}, 32'(1 << (i % 8)));
      if (i > 0) check("rr_out_valid", {31'h0, out_valid}, 32'h1);
      exp_q.push_back('{16'(16'h0100 + (i % 8)), 3'(i % 8)});
      step();
    end

    // Back-pressure while holding ch2's word
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_in_ready", {24'h0, in_ready}, 32'h0);
      check("bp_out_sel", {29'h0, out_sel}, 32'h2);
      check("bp_out_data", {16'h0, out_data}, 32'h0102);
      check("bp_out_valid", {31'h0, out_valid}, 32'h1);
      step();
    end
    out_ready = 1'b1;
    #1 check("bp_release_in_ready", {24'h0, in_ready}, 32'h08);
    exp_q.push_back('{16'h0103, 3'd3});
    step();

    // Flush with consumer stalled: ch3 word is discarded, ptr stays 4
    out_ready = 1'b0;
    flush = 1'b1;
    #1 check("flush_in_ready", {24'h0, in_ready}, 32'h0);
    step();
    flush = 1'b0;
    check("flush_out_valid", {31'h0, out_valid}, 32'h0);
    out_ready = 1'b1;
    #1 check("post_flush_in_ready", {24'h0, in_ready}, 32'h10);
    exp_q.push_back('{16'h0104, 3'd4});
    step();
    in_valid = '0;
    step();
    step();

    // NUM_IN=5 wrap: ch0, ch4, ch0, ch4
    in_data5[0 +: W]   = 16'hA000;
    in_data5[4*W +: W] = 16'hA004;
    in_valid5  = 5'b10001;
    out_ready5 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("wrap5_in_ready", {27'h0, in_ready5}, (i % 2 == 1) ? 32'h10 : 32'h01);
      if (i % 2 == 1) exp5_q.push_back('{16'hA004, 3'd4});
      else            exp5_q.push_back('{16'hA000, 3'd0});
      step();
    end
    in_valid5 = '0;
    step();
    step();

    check("queue8_empty", 32'(exp_q.size()), 32'h0);
    check("queue5_empty", 32'(exp5_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-to-1 datapath multiplexer. Select is generated internally by a round-robin arbiter, not driven by the caller.
- Successor to the fixed 8:1 one-bit select mux. Used where several pipeline sources (e.g. writeback/forwarding producers, memory requesters) share one consumer.
- Each input has a valid/ready handshake. One registered output stage gives fair, one-cycle-latency, back-pressure-aware merging.

Parameters:
- WIDTH, 16, data width per channel in bits (>=1).
- NUM_IN, 8, number of input channels (>=2; need not be a power of 2).
- Localparam SEL_W = max(1, clog2(NUM_IN)). Derived, not overridable.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of the output register (pipeline squash).
- in_data  in  NUM_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-channel request.
- in_ready  out  NUM_IN  per-channel accept. One-hot or zero.
- out_data  out  WIDTH  registered selected data.
- out_sel  out  SEL_W  registered index of the channel that supplied out_data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0. in_ready=0 while in reset.
- Two states, given by out_valid: EMPTY (0) and FULL (1).
- load_en = (!out_valid | out_ready) & !flush.
- Arbitration (combinational):
  - The winner is the first k with in_valid[k]=1, searching ptr, ptr+1, ..., NUM_IN-1, 0, ..., ptr-1.
  - in_ready[winner] = load_en. All other in_ready bits = 0.
  - No valid input means no winner and in_ready = 0.
- Transfer: an input transfer occurs when in_valid[k] & in_ready[k]. On that edge:
  - out_data <= in_data[k], out_sel <= k, out_valid <= 1.
  - ptr <= (k == NUM_IN-1) ? 0 : k+1, which wraps correctly for non-power-of-2 NUM_IN.
- Output drain with no new input: if out_valid & out_ready and no input transfer, out_valid <= 0. out_data and out_sel hold their last value.
- Simultaneous drain and load: both happen on the same edge. Output stays FULL with new data, giving sustained throughput of 1 word/cycle.
- Back-pressure: when out_valid=1 and out_ready=0, out_data and out_sel stay stable, in_ready=0, and ptr is unchanged.
- Latency: input transfer to out_valid is exactly 1 cycle. There is no combinational path from in_data to out_data.
- Known combinational paths: in_ready depends combinationally on in_valid, out_ready and flush. out_valid, out_data and out_sel are pure register outputs.
- Flush:
  - On the edge with flush=1: out_valid <= 0 and no input is accepted (in_ready=0 that cycle).
  - ptr and out_data are unchanged.
  - flush overrides out_ready and in_valid.
- Fairness: a channel holding in_valid high is granted within NUM_IN transfers.
- Input rules and don't-cares:
  - in_valid may drop without a transfer; the arbiter re-evaluates every cycle.
  - in_data of channels with in_valid=0 is don't-care.
  - An X on in_data of a non-selected channel must not propagate to the output.

Test Plan:
- Reset mid-stream: FULL with out_data=0xBEEF, assert rst_n=0 -> out_valid=0, out_data=0, out_sel=0 immediately (no clock edge needed). After release, the first grant searches from channel 0.
- Single request: in_valid=8'b0000_1000, in_data ch3=0x1234, out_ready=1 -> in_ready=8'b0000_1000 that cycle. Next cycle out_valid=1, out_data=0x1234, out_sel=3. ptr=4.
- Round-robin throughput: all 8 in_valid high, ch k data=0x0100+k, out_ready=1 continuously -> out_sel sequence 0,1,...,7,0,1 on consecutive cycles, out_valid never drops, exactly one in_ready bit high per cycle.
- Back-pressure: FULL with out_sel=2, out_ready=0 for 4 cycles with all inputs valid -> out_data and out_sel stable, in_ready=0, ptr=3. Raising out_ready loads ch3 the same edge the ch2 word drains.
- Non-power-of-2 wrap (NUM_IN=5): in_valid=5'b10001, grant ch4 -> ptr wraps to 0. The next grant is ch0, then ch4.
- Flush: FULL, out_ready=0, in_valid all high, flush=1 for one cycle -> in_ready=0 that cycle, out_valid=0 next cycle, ptr unchanged. The cycle after, the grant resumes at the unchanged ptr.
